din_debounce: RTL

Input-conditioning stage for the enable-gated flip-flop. It synchronizes an asynchronous external level into the `clk` domain and debounces it with a consecutive-sample counter. It then presents a clean level (`dout`) plus single-cycle change strobes (`e`, `e_rise`, `e_fall`). `dout` drives the downstream flop's `d` input and `e` drives its enable, so the flop captures only debounced transitions.

---
 rtl/din_debounce.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/din_debounce.sv
// Input conditioner: synchronizes an asynchronous level into clk and debounces it,
// producing a clean registered level plus one-cycle rise/fall/any-change strobes.
module din_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic       dout,
  output logic       e,
  output logic       e_rise,
  output logic       e_fall,
  output logic [7:0] glitch_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_LO      = 2'd0,
    ST_PEND_HI = 2'd1,
    ST_HI      = 2'd2,
    ST_PEND_LO = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   e_q, e_d;
  logic                   e_rise_q, e_rise_d;
  logic                   e_fall_q, e_fall_d;
  logic [7:0]             glitch_cnt_q, glitch_cnt_d;
  logic                   sync_level;

  // Bit 0 is the first synchronizer stage; the top bit is the level the FSM sees.
  assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], din};
  assign sync_level   = sync_chain_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    e_rise_d     = 1'b0;
    e_fall_d     = 1'b0;
    glitch_cnt_d = glitch_cnt_q;

    unique case (state_q)
      ST_LO: begin
        if (sync_level) begin
          if (DEBOUNCE_CNT == 1) begin
            state_d  = ST_HI;
            dout_d   = 1'b1;
            e_rise_d = 1'b1;
          end else begin
            state_d = ST_PEND_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_PEND_HI: begin
        if (!sync_level) begin
          state_d = ST_LO;
          cnt_d   = '0;
          if (glitch_cnt_q != 8'hFF) glitch_cnt_d = glitch_cnt_q + 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_HI;
          cnt_d    = '0;
          dout_d   = 1'b1;
          e_rise_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!sync_level) begin
          if (DEBOUNCE_CNT == 1) begin
            state_d  = ST_LO;
            dout_d   = 1'b0;
            e_fall_d = 1'b1;
          end else begin
            state_d = ST_PEND_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_PEND_LO: begin
        if (sync_level) begin
          state_d = ST_HI;
          cnt_d   = '0;
          if (glitch_cnt_q != 8'hFF) glitch_cnt_d = glitch_cnt_q + 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_LO;
          cnt_d    = '0;
          dout_d   = 1'b0;
          e_fall_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase

    e_d = e_rise_d | e_fall_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LO;
      sync_chain_q <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      e_q          <= 1'b0;
      e_rise_q     <= 1'b0;
      e_fall_q     <= 1'b0;
      glitch_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      sync_chain_q <= sync_chain_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      e_q          <= e_d;
      e_rise_q     <= e_rise_d;
      e_fall_q     <= e_fall_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign e          = e_q;
  assign e_rise     = e_rise_q;
  assign e_fall     = e_fall_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule
